uart_tx_arbiter: RTL and testbench

// - Shares one UART transmit path among NUM_REQ requesters.
// - Uses a round-robin grant. Issues one frame at a time on the transmitter's valid/ready interface.
// - Sits between the per-source producers (CPU mailbox, loopback, status reporter) and the single UART TX.
// - Holds the frame payload stable for the whole frame.
// - Supervises the transmitter with a start-acknowledge watchdog.
//

---
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART TX arbiter.
// master is the arbiter side, slave is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_SIZE = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]            req_err;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          tx_ready;
  logic                          tx_valid;
  logic [WIDTH_SIZE-1:0]         tx_data;
  logic                          tx_err;
  logic [IDW-1:0]                grant_id;
  logic                          busy;
  logic                          timeout;

  modport master (
    input  req_valid, req_data, req_err, tx_ready,
    output req_ack, tx_valid, tx_data, tx_err,
    output grant_id, busy, timeout
  );

  modport slave (
    output req_valid, req_data, req_err, tx_ready,
    input  req_ack, tx_valid, tx_data, tx_err,
    input  grant_id, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ sources.
// One frame outstanding; start-acknowledge watchdog while issuing.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH_SIZE  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ACK1 = NUM_REQ'(1);
  localparam logic [7:0] WD_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] next_ptr;
  logic [7:0]     wd_cnt;
  logic           any_req;

  // First requesting source at or after rr_ptr, wrapping
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    idx     = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && bus.req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  assign next_ptr = (bus.grant_id == LAST) ?
                    '0 : bus.grant_id + 1'b1;

  // Grant, issue and completion sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      bus.req_ack  <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_err   <= 1'b0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.timeout  <= 1'b0;
    end else begin
      bus.req_ack <= '0;
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.tx_ready && any_req) begin
            bus.tx_data <=
              bus.req_data[winner*WIDTH_SIZE +: WIDTH_SIZE];
            bus.tx_err   <= bus.req_err[winner];
            bus.grant_id <= winner;
            bus.req_ack  <= ACK1 << winner;
            bus.busy     <= 1'b1;
            bus.tx_valid <= 1'b1;
            wd_cnt       <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            state        <= WAIT_DONE;
          end else if (wd_cnt == WD_LAST) begin
            bus.tx_valid <= 1'b0;
            bus.timeout  <= 1'b1;
            bus.busy     <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) begin
            bus.busy <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scenario tasks, scoreboard of
// round-robin grants and a small transmitter model.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TO  = 16;
  localparam int FL  = 11;
  localparam int IDW = $clog2(N);

  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.NUM_REQ(N), .WIDTH_SIZE(W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .WIDTH_SIZE(W),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_mode = 0;
  int xmit_cnt = 0;
  bit hold_req = 1'b0;
  int m_ptr = 0;
  int glog[$];
  logic [N-1:0] prev_ack = '0;

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // One clock: scoreboard, requester and transmitter models
  task automatic step();
    logic [N-1:0]   sv = bus.req_valid;
    logic [N*W-1:0] sd = bus.req_data;
    logic [N-1:0]   se = bus.req_err;
    logic pv = bus.tx_valid;
    logic pr = bus.tx_ready;
    logic [N-1:0] ea;
    logic [W-1:0] ed;
    int ew;
    @(posedge clk);
    #1;
    if (prev_ack != '0) begin
      n_tests++;
      if (bus.req_ack !== '0) begin
        n_fail++;
        $display("FAIL ack_width: ack=%b want 0", bus.req_ack);
      end
    end
    if (bus.req_ack != '0) begin
      ew = model_winner(sv);
      n_tests++;
      if (ew < 0) begin
        n_fail++;
        $display("FAIL grant_none: ack=%b want none", bus.req_ack);
      end else begin
        ea = '0;
        ea[ew] = 1'b1;
        ed = sd[ew*W +: W];
        if (bus.req_ack !== ea || bus.grant_id !== ew[IDW-1:0] ||
            bus.tx_data !== ed || bus.tx_err !== se[ew] ||
            bus.tx_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL grant: ack=%b id=%0d d=%h e=%b v=%b want ack=%b id=%0d d=%h e=%b v=1",
                   bus.req_ack, bus.grant_id, bus.tx_data, bus.tx_err,
                   bus.tx_valid, ea, ew, ed, se[ew]);
        end
        m_ptr = (ew + 1) % N;
        glog.push_back(ew);
        if (!hold_req) bus.req_valid[ew] = 1'b0;
        bus.req_data[ew*W +: W] = W'($urandom);
        bus.req_err[ew] = 1'($urandom_range(0, 1));
      end
    end
    case (tx_mode)
      0: begin
        if (xmit_cnt > 0) begin
          xmit_cnt--;
          if (xmit_cnt == 0) bus.tx_ready = 1'b1;
        end else if (pv && pr) begin
          bus.tx_ready = 1'b0;
          xmit_cnt = FL;
        end
      end
      1: bus.tx_ready = 1'b1;
      default: ;
    endcase
    prev_ack = bus.req_ack;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    bus.tx_ready  = 1'b1;
    bus.req_valid = '0;
    bus.req_err   = '0;
    bus.req_data  = {$urandom, $urandom};
    xmit_cnt = 0;
    m_ptr = 0;
    prev_ack = '0;
    glog.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int c = 0;
    while (bus.busy && c < limit) begin
      step();
      c++;
    end
    ok = !bus.busy;
  endtask

  task automatic wait_grants(input int n, input int limit,
                             output bit ok);
    int c = 0;
    while (glog.size() < n && c < limit) begin
      step();
      c++;
    end
    ok = (glog.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tx_ready = 1'b1;
    bus.req_valid = '1;
    #3;
    n_tests++;
    if ({bus.tx_valid, bus.tx_data, bus.tx_err, bus.req_ack,
         bus.grant_id, bus.busy, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: v=%b d=%h e=%b ack=%b id=%0d b=%b t=%b want all 0",
               bus.tx_valid, bus.tx_data, bus.tx_err, bus.req_ack,
               bus.grant_id, bus.busy, bus.timeout);
    end
    reset_dut();
    step();
    n_tests++;
    if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: v=%b b=%b want 0 0",
               bus.tx_valid, bus.busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    bit stable = 1'b1;
    reset_dut();
    tx_mode = 0;
    hold_req = 1'b0;
    bus.req_data[0 +: W] = 8'hA5;
    bus.req_err[0] = 1'b0;
    bus.req_valid = 4'b0001;
    step();
    n_tests++;
    if (bus.req_ack !== 4'b0001 || bus.tx_valid !== 1'b1 ||
        bus.tx_data !== 8'hA5 || bus.grant_id !== '0) begin
      n_fail++;
      $display("FAIL single: ack=%b v=%b d=%h id=%0d want 0001 1 a5 0",
               bus.req_ack, bus.tx_valid, bus.tx_data, bus.grant_id);
    end
    for (int c = 0; c < 40 && bus.busy; c++) begin
      step();
      if (bus.tx_data !== 8'hA5) stable = 1'b0;
    end
    ok = !bus.busy;
    n_tests++;
    if (!ok || !stable) begin
      n_fail++;
      $display("FAIL single_done: idle=%b stable=%b want 1 1",
               ok, stable);
    end
  endtask

  task automatic test_round_robin();
    int gap = 0;
    int seen = 0;
    bit gap_ok = 1'b1;
    int want[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    tx_mode = 0;
    hold_req = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 200 && glog.size() < 5; c++) begin
      step();
      if (glog.size() > seen) begin
        if (seen > 0 && gap != 1) begin
          gap_ok = 1'b0;
          $display("FAIL rr_gap: idle=%0d want 1", gap);
        end
        seen = glog.size();
        gap = 0;
      end else if (!bus.busy) begin
        gap++;
      end
    end
    n_tests++;
    if (!gap_ok) n_fail++;
    n_tests++;
    if (glog.size() < 5) begin
      n_fail++;
      $display("FAIL rr_count: grants=%0d want 5", glog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (glog[i] != want[i]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: got %0d want %0d",
                   i, glog[i], want[i]);
        end
      end
    end
    hold_req = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    int want[3] = '{0, 2, 0};
    reset_dut();
    tx_mode = 0;
    hold_req = 1'b0;
    bus.req_valid = 4'b0100;
    wait_grants(1, 20, ok);
    wait_idle(40, ok);
    hold_req = 1'b1;
    bus.req_valid = 4'b0101;
    wait_grants(4, 200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_count: grants=%0d want 4", glog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (glog[i+1] != want[i]) begin
          n_fail++;
          $display("FAIL wrap[%0d]: got %0d want %0d",
                   i, glog[i+1], want[i]);
        end
      end
    end
    hold_req = 1'b0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    reset_dut();
    tx_mode = 1;
    hold_req = 1'b0;
    bus.req_valid = 4'b0011;
    step();
    for (int c = 0; c < 40 && bus.tx_valid; c++) begin
      hi++;
      step();
    end
    n_tests++;
    if (hi != TO || bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: high=%0d t=%b b=%b want %0d 1 0",
               hi, bus.timeout, bus.busy, TO);
    end
    step();
    n_tests++;
    if (bus.timeout !== 1'b0 || bus.tx_valid !== 1'b1 ||
        bus.grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_next: t=%b v=%b id=%0d want 0 1 1",
               bus.timeout, bus.tx_valid, bus.grant_id);
    end
    tx_mode = 0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    tx_mode = 0;
    hold_req = 1'b1;
    bus.req_valid = 4'b0010;
    step();
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.tx_valid, bus.tx_data, bus.tx_err, bus.req_ack,
         bus.grant_id, bus.busy, bus.timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b d=%h e=%b ack=%b id=%0d b=%b t=%b want all 0",
               bus.tx_valid, bus.tx_data, bus.tx_err, bus.req_ack,
               bus.grant_id, bus.busy, bus.timeout);
    end
    bus.tx_ready = 1'b1;
    xmit_cnt = 0;
    m_ptr = 0;
    prev_ack = '0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.timeout !== 1'b0 || bus.req_ack !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: t=%b ack=%b want 0 0",
               bus.timeout, bus.req_ack);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (bus.req_ack !== 4'b0010 || bus.grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_regrant: ack=%b id=%0d want 0010 1",
               bus.req_ack, bus.grant_id);
    end
    hold_req = 1'b0;
  endtask

  task automatic test_start_race();
    bit tseen = 1'b0;
    reset_dut();
    tx_mode = 2;
    hold_req = 1'b0;
    bus.req_valid = 4'b0100;
    step();
    repeat (TO - 1) step();
    n_tests++;
    if (bus.tx_valid !== 1'b1 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL race_pre: v=%b t=%b want 1 0",
               bus.tx_valid, bus.timeout);
    end
    bus.tx_ready = 1'b0;
    step();
    n_tests++;
    if (bus.timeout !== 1'b0 || bus.tx_valid !== 1'b0 ||
        bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL race_start: t=%b v=%b b=%b want 0 0 1",
               bus.timeout, bus.tx_valid, bus.busy);
    end
    repeat (5) begin
      step();
      if (bus.timeout || !bus.busy) tseen = 1'b1;
    end
    bus.tx_ready = 1'b1;
    step();
    n_tests++;
    if (tseen || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL race_done: early=%b b=%b t=%b want 0 0 0",
               tseen, bus.busy, bus.timeout);
    end
    tx_mode = 0;
  endtask

  task automatic test_random();
    reset_dut();
    tx_mode = 0;
    hold_req = 1'b0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          bus.req_data[i*W +: W] = W'($urandom);
          bus.req_err[i] = 1'($urandom_range(0, 1));
          bus.req_valid[i] = 1'b1;
        end
      end
      step();
    end
    n_tests++;
    if (glog.size() < 15) begin
      n_fail++;
      $display("FAIL random_count: grants=%0d want >=15",
               glog.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_start_race();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1);
  end
endmodule
